ripple_count_monitor: RTL

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

---
 rtl/ripple_count_monitor.sv | 91 +++++++++
 1 files changed

// File: rtl/ripple_count_monitor.sv
// Clock-domain monitor for an asynchronous 4-bit ripple counter: synchronizes and
// filters the raw count, flags steps/wraps/matches, and checks the sequence is legal.
module ripple_count_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q_in,
  input  logic [3:0]        cmp_val,
  input  logic              clr,
  output logic [3:0]        count,
  output logic              step,
  output logic              wrap,
  output logic              match,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              skip_err
);

  logic [3:0] s1_r;
  logic [3:0] s2_r;
  logic [3:0] s3_r;
  logic       update_s;
  logic       wrap_s;
  logic       legal_s;
  logic       match_s;

  // A counter may only advance by one or restart at zero.
  function automatic logic legal_seq(input logic [3:0] old_v, input logic [3:0] new_v);
    legal_seq = (new_v == (old_v + 4'd1)) || (new_v == 4'd0);
  endfunction

  // Update decode: s2 must agree with s3 so a rippling sample never reaches count.
  always_comb begin
    update_s = 1'b0;
    wrap_s   = 1'b0;
    legal_s  = 1'b1;
    match_s  = 1'b0;
    if ((s2_r == s3_r) && (s2_r != count)) begin
      update_s = 1'b1;
      wrap_s   = (count == 4'd15) && (s2_r == 4'd0);
      legal_s  = legal_seq(count, s2_r);
      match_s  = (s2_r == cmp_val);
    end else begin
      update_s = 1'b0;
    end
  end

  // Synchronizer, filtered count, pulses and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r     <= 4'd0;
      s2_r     <= 4'd0;
      s3_r     <= 4'd0;
      count    <= 4'd0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      match    <= 1'b0;
      wrap_cnt <= '0;
      skip_err <= 1'b0;
    end else begin
      s1_r  <= q_in;
      s2_r  <= s1_r;
      s3_r  <= s2_r;
      step  <= update_s;
      wrap  <= wrap_s;
      match <= match_s;
      if (update_s) begin
        count <= s2_r;
      end else begin
        count <= count;
      end
      // clr beats both a saturating increment and an error set on the same edge.
      if (clr) begin
        wrap_cnt <= '0;
        skip_err <= 1'b0;
      end else begin
        if (wrap_s && (wrap_cnt != '1)) begin
          wrap_cnt <= wrap_cnt + WRAP_W'(1);
        end else begin
          wrap_cnt <= wrap_cnt;
        end
        if (update_s && !legal_s) begin
          skip_err <= 1'b1;
        end else begin
          skip_err <= skip_err;
        end
      end
    end
  end

endmodule
